// File: rtl/alu_operand_sequencer.sv
// Board front end for the 32-bit ALU: collects A, B and opcode on load presses,
// waits a settle time, then captures result/flags. Optional build macro: ALU_ACC_CHAIN_EN.
module alu_operand_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [3:0]       op_in,
    input  logic             load_btn,
    input  logic             clear,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [2:0]       stage,
    output logic             done,
    output logic             err
);
    // state  | meaning
    // S_A    | waiting for operand A press
    // S_B    | waiting for operand B press
    // S_OP   | waiting for opcode press
    // S_EXEC | ALU inputs settling, counting down to capture
    // S_SHOW | result/flags valid for display
    // S_ERR  | invalid opcode entered, next press re-enters opcode
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load_prev;
    logic             ld;
    logic [WIDTH-1:0] a_d, b_d, res_d;
    logic [3:0]       op_d, flags_d;
    logic             done_d, err_d;

    assign ld = load_btn & ~load_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_A;
            cnt_q     <= '0;
            load_prev <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            result    <= '0;
            flags     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_prev <= load_btn;
            alu_a     <= a_d;
            alu_b     <= b_d;
            alu_op    <= op_d;
            result    <= res_d;
            flags     <= flags_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = alu_a;
        b_d     = alu_b;
        op_d    = alu_op;
        res_d   = result;
        flags_d = flags;
        done_d  = done;
        err_d   = err;
        if (clear) begin
            state_d = S_A;
            cnt_d   = '0;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            res_d   = '0;
            flags_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_A: if (ld) begin
                    a_d     = data_in;
                    state_d = S_B;
                end
                S_B: if (ld) begin
                    b_d     = data_in;
                    state_d = S_OP;
                end
                S_OP: if (ld) begin
                    if (op_in <= 4'd9) begin
                        op_d    = op_in;
                        // counts down from SETTLE_CYCLES-1; capture on terminal count
                        cnt_d   = CW'(SETTLE_CYCLES - 1);
                        state_d = S_EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        res_d   = alu_y;
                        flags_d = {alu_n, alu_z, alu_c, alu_v};
                        done_d  = 1'b1;
                        state_d = S_SHOW;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_SHOW: if (ld) begin
                    done_d  = 1'b0;
`ifdef ALU_ACC_CHAIN_EN
                    a_d     = result;
                    state_d = S_B;
`else
                    state_d = S_A;
`endif
                end
                S_ERR: if (ld) begin
                    err_d   = 1'b0;
                    state_d = S_OP;
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign stage = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed plan steps plus randomized presses
// checked against a press-level reference model and a behavioural ALU.
module tb_alu_operand_sequencer;
    localparam int W      = 32;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  data_in = '0;
    logic [3:0]    op_in = '0;
    logic          load_btn = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  alu_y;
    logic          alu_n, alu_z, alu_c, alu_v;
    logic [W-1:0]  alu_a, alu_b, result;
    logic [3:0]    alu_op, flags;
    logic [2:0]    stage;
    logic          done, err;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            m_stage;
    logic [W-1:0]  m_a, m_b, m_res;
    logic [3:0]    m_op, m_flags;
    logic          m_done, m_err;

    alu_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .op_in(op_in),
        .load_btn(load_btn), .clear(clear), .alu_y(alu_y),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .result(result),
        .flags(flags), .stage(stage), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    // returns {N,Z,C,V,y}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
        logic [32:0] t;
        logic [31:0] y;
        logic        c, v;
        t = '0; y = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                t = {1'b0, a} + {1'b0, b};
                y = t[31:0]; c = t[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd1: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                y = t[31:0]; c = t[32];
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd2: y = a | b;
            4'd3: y = a ^ b;
            4'd4: y = ~(a | b);
            4'd5: y = a & b;
            4'd6: y = a << b[4:0];
            4'd7: y = a >> b[4:0];
            4'd8: y = $signed(a) >>> b[4:0];
            4'd9: y = {31'b0, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
        return {y[31], (y == 32'd0), c, v, y};
    endfunction

    always_comb begin
        {alu_n, alu_z, alu_c, alu_v, alu_y} = alu_fn(alu_a, alu_b, alu_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".stage"},  32'(stage),   32'(m_stage));
        chk({tag, ".alu_a"},  alu_a,        m_a);
        chk({tag, ".alu_b"},  alu_b,        m_b);
        chk({tag, ".alu_op"}, 32'(alu_op),  32'(m_op));
        chk({tag, ".result"}, result,       m_res);
        chk({tag, ".flags"},  32'(flags),   32'(m_flags));
        chk({tag, ".done"},   32'(done),    32'(m_done));
        chk({tag, ".err"},    32'(err),     32'(m_err));
    endtask

    task automatic model_zero();
        m_stage = 0; m_a = '0; m_b = '0; m_op = '0;
        m_res = '0; m_flags = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    // effect of one accepted load press, at the level of the user procedure
    task automatic model_ld(input logic [31:0] d, input logic [3:0] op);
        case (m_stage)
            0: begin m_a = d; m_stage = 1; end
            1: begin m_b = d; m_stage = 2; end
            2: if (op <= 4'd9) begin m_op = op; m_stage = 3; end
               else begin m_err = 1'b1; m_stage = 5; end
            4: begin
                m_done = 1'b0;
`ifdef ALU_ACC_CHAIN_EN
                m_a = m_res; m_stage = 1;
`else
                m_stage = 0;
`endif
            end
            5: begin m_err = 1'b0; m_stage = 2; end
            default: ;
        endcase
    endtask

    task automatic run_exec();
        for (int i = 0; i < SETTLE; i++) begin
            chk("settle.done", 32'(done), 32'd0);
            chk("settle.stage", 32'(stage), 32'd3);
            tick();
        end
        {m_flags, m_res} = alu_fn(m_a, m_b, m_op);
        m_done = 1'b1;
        m_stage = 4;
        check_all("exec");
    endtask

    task automatic press(input logic [31:0] d, input logic [3:0] op);
        data_in = d; op_in = op; load_btn = 1'b1;
        tick();
        load_btn = 1'b0;
        model_ld(d, op);
        if (m_stage == 3) run_exec();
        else tick();
        check_all("press");
    endtask

    task automatic start_exec(input logic [31:0] a, input logic [31:0] b);
        press(a, 4'd0);
        press(b, 4'd0);
        data_in = '0; op_in = 4'd0; load_btn = 1'b1;
        tick();
        load_btn = 1'b0;
        model_ld('0, 4'd0);
        check_all("exec_start");
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        check_all("clear");
    endtask

    initial begin
        model_zero();
        tick(); tick();
        check_all("reset_held");
        rst = 1'b0;
        tick();
        check_all("reset_released");

        // add 5 + 7
        press(32'd5, 4'd0);
        press(32'd7, 4'd0);
        press(32'd0, 4'd0);
        chk("add.result", result, 32'd12);
        chk("add.flags", 32'(flags), 32'd0);
        chk("add.stage", 32'(stage), 32'd4);

        // press in S_SHOW
        press(32'd0, 4'd0);
`ifdef ALU_ACC_CHAIN_EN
        chk("chain.stage", 32'(stage), 32'd1);
        press(32'd3, 4'd0);
        press(32'd0, 4'd0);
        chk("chain.alu_a", alu_a, 32'd12);
        chk("chain.result", result, 32'd15);
        do_clear();
`else
        chk("show_ld.stage", 32'(stage), 32'd0);
`endif

        // subtract 3 - 5
        press(32'd3, 4'd0);
        press(32'd5, 4'd0);
        press(32'd0, 4'd1);
        chk("sub.result", result, 32'hFFFF_FFFE);
        chk("sub.n", 32'(flags[3]), 32'd1);
        chk("sub.z", 32'(flags[2]), 32'd0);

        // held button: one load only
        do_clear();
        data_in = 32'hA5A5_0001; load_btn = 1'b1;
        tick();
        model_ld(32'hA5A5_0001, 4'd0);
        check_all("held_first");
        for (int i = 0; i < 9; i++) begin
            tick();
            check_all("held");
        end
        load_btn = 1'b0;
        tick();
        check_all("held_release");

        // clear wins over a simultaneous press
        data_in = 32'h77; load_btn = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        check_all("clr_prio");
        tick();
        check_all("clr_prio_hold");
        load_btn = 1'b0;
        tick();

        // invalid opcode, recovery, AND
        press(32'hF0F0_1234, 4'd0);
        press(32'h0FF0_FFFF, 4'd0);
        press(32'd0, 4'hC);
        chk("inv.err", 32'(err), 32'd1);
        chk("inv.stage", 32'(stage), 32'd5);
        chk("inv.alu_op", 32'(alu_op), 32'd0);
        press(32'd0, 4'd0);
        chk("inv_recover.stage", 32'(stage), 32'd2);
        press(32'd0, 4'd5);
        chk("and.result", result, 32'h00F0_1234);

        // clear during settle
        do_clear();
        start_exec(32'd9, 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_zero();
        check_all("exec_clear");
        for (int i = 0; i <= SETTLE; i++) tick();
        check_all("exec_clear_after");

        // asynchronous reset during settle
        start_exec(32'd9, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        model_zero();
        check_all("exec_async_rst");
        tick();
        rst = 1'b0;
        tick();
        check_all("exec_rst_after");

        // randomized presses
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_clear();
            end else begin
                logic [3:0] op;
                if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(10, 15));
                else op = 4'($urandom_range(0, 9));
                press($urandom, op);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
